// File: rtl/beam_sweep_scheduler_if.sv
// Control/result bundle between the sweep scheduler and the TX/RX chain.
// The slave modport is the scheduler side; master is the driver side.
interface beam_sweep_scheduler_if #(
    parameter int ANGLE_WIDTH = 8,
    parameter int RANGE_WIDTH = 16
);
    logic                          enable_in;
    logic                          result_valid_in;
    logic        [RANGE_WIDTH-1:0] range_in;
    logic                          burst_start_out;
    logic                          burst_active_out;
    logic                          listen_active_out;
    logic signed [ANGLE_WIDTH-1:0] beam_angle_out;
    logic                          sweep_done_out;
    logic signed [ANGLE_WIDTH-1:0] best_angle_out;
    logic        [RANGE_WIDTH-1:0] best_range_out;
    logic                          best_valid_out;

    modport master (
        output enable_in, result_valid_in, range_in,
        input  burst_start_out, burst_active_out, listen_active_out, beam_angle_out,
        input  sweep_done_out, best_angle_out, best_range_out, best_valid_out
    );

    modport slave (
        input  enable_in, result_valid_in, range_in,
        output burst_start_out, burst_active_out, listen_active_out, beam_angle_out,
        output sweep_done_out, best_angle_out, best_range_out, best_valid_out
    );
endinterface

// File: rtl/beam_sweep_scheduler.sv
// Stepped beam sweep sequencer: one burst+listen dwell per angle, nearest-target publish per sweep.
// Optional SWEEP_PING_PONG_EN reverses the sweep direction after every publish.
module beam_sweep_scheduler #(
    parameter int PERIOD_CYCLES = 16777216,
    parameter int BURST_CYCLES  = 524288,
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10,
    parameter int RANGE_WIDTH   = 16
) (
    input logic clk_in,
    input logic rst_in,
    beam_sweep_scheduler_if.slave bus
);
    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] BURST_LAST  = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

    typedef enum logic [1:0] {IDLE, BURST, LISTEN, PUBLISH} state_t;

    state_t                          state_reg;
    logic        [CW-1:0]            cnt_reg;
    logic signed [ANGLE_WIDTH-1:0]   angle_reg;
    logic                            captured_reg;
    logic                            any_reg;
    logic        [RANGE_WIDTH-1:0]   min_range_reg;
    logic signed [ANGLE_WIDTH-1:0]   min_angle_reg;
    logic                            burst_start_reg;
    logic                            burst_active_reg;
    logic                            listen_active_reg;
    logic                            sweep_done_reg;
    logic signed [ANGLE_WIDTH-1:0]   best_angle_reg;
    logic        [RANGE_WIDTH-1:0]   best_range_reg;
    logic                            best_valid_reg;

    // sweep_desc: direction of the sweep in progress (or about to start from IDLE);
    // next_desc: direction of the sweep that follows a PUBLISH.
    logic sweep_desc;
    logic next_desc;
`ifdef SWEEP_PING_PONG_EN
    logic desc_reg;
    assign sweep_desc = desc_reg;
    assign next_desc  = ~desc_reg;
`else
    assign sweep_desc = 1'b0;
    assign next_desc  = 1'b0;
`endif

    logic signed [ANGLE_WIDTH-1:0] last_angle;
    logic signed [ANGLE_WIDTH-1:0] stepped_angle;
    logic signed [ANGLE_WIDTH-1:0] idle_start_angle;
    logic signed [ANGLE_WIDTH-1:0] restart_angle;

    assign last_angle       = sweep_desc ? A_MIN : A_MAX;
    assign stepped_angle    = sweep_desc ? (angle_reg - A_STEP) : (angle_reg + A_STEP);
    assign idle_start_angle = sweep_desc ? A_MAX : A_MIN;
    assign restart_angle    = next_desc ? A_MAX : A_MIN;

    // Merge the current-cycle strobe into the running minimum so a capture on the
    // final LISTEN cycle still reaches the PUBLISH outputs.
    logic                          accept;
    logic                          take;
    logic                          merged_any;
    logic        [RANGE_WIDTH-1:0] merged_range;
    logic signed [ANGLE_WIDTH-1:0] merged_angle;

    assign accept       = (state_reg == LISTEN) && bus.result_valid_in && !captured_reg;
    assign take         = accept && (!any_reg || (bus.range_in < min_range_reg));
    assign merged_any   = any_reg | accept;
    assign merged_range = take ? bus.range_in : min_range_reg;
    assign merged_angle = take ? angle_reg : min_angle_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            angle_reg         <= A_MIN;
            captured_reg      <= 1'b0;
            any_reg           <= 1'b0;
            min_range_reg     <= '0;
            min_angle_reg     <= '0;
            burst_start_reg   <= 1'b0;
            burst_active_reg  <= 1'b0;
            listen_active_reg <= 1'b0;
            sweep_done_reg    <= 1'b0;
            best_angle_reg    <= '0;
            best_range_reg    <= '0;
            best_valid_reg    <= 1'b0;
`ifdef SWEEP_PING_PONG_EN
            desc_reg          <= 1'b0;
`endif
        end else begin
            burst_start_reg <= 1'b0;
            sweep_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.enable_in) begin
                        state_reg        <= BURST;
                        cnt_reg          <= '0;
                        angle_reg        <= idle_start_angle;
                        burst_start_reg  <= 1'b1;
                        burst_active_reg <= 1'b1;
                        captured_reg     <= 1'b0;
                        any_reg          <= 1'b0;
                        min_range_reg    <= '0;
                        min_angle_reg    <= '0;
                    end
                end
                BURST: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == BURST_LAST) begin
                        state_reg         <= LISTEN;
                        burst_active_reg  <= 1'b0;
                        listen_active_reg <= 1'b1;
                    end
                end
                LISTEN: begin
                    if (accept) begin
                        captured_reg <= 1'b1;
                        any_reg      <= 1'b1;
                    end
                    if (take) begin
                        min_range_reg <= bus.range_in;
                        min_angle_reg <= angle_reg;
                    end
                    if (cnt_reg == PERIOD_LAST) begin
                        cnt_reg           <= '0;
                        captured_reg      <= 1'b0;
                        listen_active_reg <= 1'b0;
                        if (angle_reg == last_angle) begin
                            state_reg      <= PUBLISH;
                            sweep_done_reg <= 1'b1;
                            best_valid_reg <= merged_any;
                            if (merged_any) begin
                                best_angle_reg <= merged_angle;
                                best_range_reg <= merged_range;
                            end
                        end else begin
                            state_reg        <= BURST;
                            angle_reg        <= stepped_angle;
                            burst_start_reg  <= 1'b1;
                            burst_active_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                PUBLISH: begin
`ifdef SWEEP_PING_PONG_EN
                    desc_reg <= ~desc_reg;
`endif
                    if (bus.enable_in) begin
                        state_reg        <= BURST;
                        cnt_reg          <= '0;
                        angle_reg        <= restart_angle;
                        burst_start_reg  <= 1'b1;
                        burst_active_reg <= 1'b1;
                        captured_reg     <= 1'b0;
                        any_reg          <= 1'b0;
                        min_range_reg    <= '0;
                        min_angle_reg    <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.burst_start_out   = burst_start_reg;
    assign bus.burst_active_out  = burst_active_reg;
    assign bus.listen_active_out = listen_active_reg;
    assign bus.beam_angle_out    = angle_reg;
    assign bus.sweep_done_out    = sweep_done_reg;
    assign bus.best_angle_out    = best_angle_reg;
    assign bus.best_range_out    = best_range_reg;
    assign bus.best_valid_out    = best_valid_reg;
endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Directed bench for beam_sweep_scheduler with PERIOD_CYCLES=20, BURST_CYCLES=4.
// Expected angles follow SWEEP_PING_PONG_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_beam_sweep_scheduler;
    localparam int PER = 20;
    localparam int BUR = 4;
    localparam int NDW = 7;
    localparam int SWEEP_CYC = NDW * PER;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    beam_sweep_scheduler_if #(.ANGLE_WIDTH(8), .RANGE_WIDTH(16)) bus ();

    beam_sweep_scheduler #(
        .PERIOD_CYCLES(PER),
        .BURST_CYCLES (BUR)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Strobe table for the sweep being run: dwell index, dwell cycle, range.
    int st_n;
    int st_dwell [4];
    int st_cnt   [4];
    int st_rng   [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge at sweep cycle c0; walks to cycle c1 checking dwell timing.
    task automatic run_sweep(input int a0, input int stp, input int c0, input int c1);
        int k;
        int cnt;
        for (int c = c0; c < c1; c++) begin
            k   = c / PER;
            cnt = c % PER;
            if (cnt == 0)
                $display("t=%0t dwell %0d start angle=%0d (expect %0d)",
                         $time, k, $signed(bus.beam_angle_out), a0 + k * stp);
            chk("burst_start",   bus.burst_start_out,   (cnt == 0) ? 1 : 0);
            chk("burst_active",  bus.burst_active_out,  (cnt < BUR) ? 1 : 0);
            chk("listen_active", bus.listen_active_out, (cnt >= BUR) ? 1 : 0);
            chk("beam_angle",    $signed(bus.beam_angle_out), a0 + k * stp);
            chk("sweep_done_mid", bus.sweep_done_out, 0);
            bus.result_valid_in = 1'b0;
            bus.range_in        = '0;
            for (int i = 0; i < st_n; i++) begin
                if (st_dwell[i] == k && st_cnt[i] == cnt) begin
                    bus.result_valid_in = 1'b1;
                    bus.range_in        = 16'(st_rng[i]);
                end
            end
            step();
        end
        bus.result_valid_in = 1'b0;
        bus.range_in        = '0;
    endtask

    task automatic chk_publish(input int valid, input int angle, input int rng);
        $display("t=%0t publish valid=%0d angle=%0d range=%0d (expect %0d/%0d/%0d)",
                 $time, bus.best_valid_out, $signed(bus.best_angle_out), bus.best_range_out,
                 valid, angle, rng);
        chk("sweep_done",     bus.sweep_done_out, 1);
        chk("pub_burst",      bus.burst_active_out, 0);
        chk("pub_listen",     bus.listen_active_out, 0);
        chk("best_valid",     bus.best_valid_out, valid);
        chk("best_angle",     $signed(bus.best_angle_out), angle);
        chk("best_range",     bus.best_range_out, rng);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_burst_start"},  bus.burst_start_out, 0);
        chk({tag, "_burst_active"}, bus.burst_active_out, 0);
        chk({tag, "_listen"},       bus.listen_active_out, 0);
        chk({tag, "_sweep_done"},   bus.sweep_done_out, 0);
        chk({tag, "_angle"},        $signed(bus.beam_angle_out), -30);
        chk({tag, "_best_angle"},   $signed(bus.best_angle_out), 0);
        chk({tag, "_best_range"},   bus.best_range_out, 0);
        chk({tag, "_best_valid"},   bus.best_valid_out, 0);
    endtask

    int s2_a0, s2_st, s2_best_angle, s4_a0, s4_st;

    initial begin
`ifdef SWEEP_PING_PONG_EN
        s2_a0 = 30;  s2_st = -10; s2_best_angle = -30;
        s4_a0 = 30;  s4_st = -10;
`else
        s2_a0 = -30; s2_st = 10;  s2_best_angle = 30;
        s4_a0 = -30; s4_st = 10;
`endif
        rst = 1'b1;
        bus.enable_in       = 1'b0;
        bus.result_valid_in = 1'b0;
        bus.range_in        = '0;
        st_n = 0;
        repeat (3) step();
        chk_reset_state("reset");

        // Sweep 1: 500@-10, 120@20 (first LISTEN cycle), 120@30 on final LISTEN cycle (tie keeps 20).
        rst = 1'b0;
        bus.enable_in = 1'b1;
        step();
        st_n = 3;
        st_dwell[0] = 2; st_cnt[0] = 10; st_rng[0] = 500;
        st_dwell[1] = 5; st_cnt[1] = 4;  st_rng[1] = 120;
        st_dwell[2] = 6; st_cnt[2] = 19; st_rng[2] = 120;
        run_sweep(-30, 10, 0, SWEEP_CYC);
        chk_publish(1, 20, 120);
        step();

        // Sweep 2: BURST strobe 10, then 300 and 50 in LISTEN of dwell 0; 250 on final cycle of last dwell.
        st_n = 4;
        st_dwell[0] = 0; st_cnt[0] = 2;  st_rng[0] = 10;
        st_dwell[1] = 0; st_cnt[1] = 5;  st_rng[1] = 300;
        st_dwell[2] = 0; st_cnt[2] = 9;  st_rng[2] = 50;
        st_dwell[3] = 6; st_cnt[3] = 19; st_rng[3] = 250;
        run_sweep(s2_a0, s2_st, 0, SWEEP_CYC);
        chk_publish(1, s2_best_angle, 250);
        step();

        // Sweep 3: no strobes, enable dropped mid-sweep; previous best held.
        st_n = 0;
        run_sweep(-30, 10, 0, 70);
        bus.enable_in = 1'b0;
        run_sweep(-30, 10, 70, SWEEP_CYC);
        chk_publish(0, s2_best_angle, 250);
        step();
        chk("idle_burst_start",  bus.burst_start_out, 0);
        chk("idle_burst_active", bus.burst_active_out, 0);
        chk("idle_listen",       bus.listen_active_out, 0);
        chk("idle_sweep_done",   bus.sweep_done_out, 0);
        step();
        chk("idle_stays",        bus.burst_start_out, 0);

        // Sweep 4: reset for one cycle mid-LISTEN at angle 0.
        bus.enable_in = 1'b1;
        step();
        run_sweep(s4_a0, s4_st, 0, 70);
        rst = 1'b1;
        step();
        chk_reset_state("midreset");
        rst = 1'b0;
        // Strobe while IDLE must be ignored.
        bus.result_valid_in = 1'b1;
        bus.range_in        = 16'd1;
        step();
        bus.result_valid_in = 1'b0;
        bus.range_in        = '0;

        // Sweep 5: restarts at -30 ascending; single capture 77@-20.
        st_n = 1;
        st_dwell[0] = 1; st_cnt[0] = 12; st_rng[0] = 77;
        run_sweep(-30, 10, 0, SWEEP_CYC);
        chk_publish(1, -20, 77);
        bus.enable_in = 1'b0;
        step();
        chk("end_idle", bus.burst_start_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/beam_sweep_scheduler.md
# beam_sweep_scheduler

Sequences the transmit/receive chain through a stepped beam sweep. The block emits one burst per angle dwell, drives the steering angle into the sine lookup and the TX/RX beamformers, and opens the listen window. It collects one time-of-flight range per dwell and publishes the nearest target's angle and range at the end of each sweep. It replaces the free-running burst timer and fixed zero angle in the top level, and feeds the seven-segment controller's angle and distance inputs.

## Interface
- PERIOD_CYCLES, 16777216: dwell length per angle, in clocks (burst plus listen).
- BURST_CYCLES, 524288: transmit window at the start of each dwell; must be less than PERIOD_CYCLES.
- ANGLE_WIDTH, 8: signed angle width, in degrees.
- ANGLE_MIN, -30: first angle. ANGLE_MAX, 30: last angle. ANGLE_STEP, 10: increment; (ANGLE_MAX-ANGLE_MIN) must be divisible by ANGLE_STEP.
- RANGE_WIDTH, 16: range width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- enable_in  input  1  run sweeps while high
- result_valid_in  input  1  one-cycle range-valid strobe from time_of_flight
- range_in  input  RANGE_WIDTH  range, sampled when result_valid_in is high
- burst_start_out  output  1  one-cycle pulse on the first cycle of each dwell; resets the TX/RX/SPI chain
- burst_active_out  output  1  high during the transmit window
- listen_active_out  output  1  high during the listen window
- beam_angle_out  output  ANGLE_WIDTH signed  current steering angle
- sweep_done_out  output  1  one-cycle pulse in PUBLISH
- best_angle_out  output  ANGLE_WIDTH signed  angle of the nearest target from the last sweep
- best_range_out  output  RANGE_WIDTH  nearest range from the last sweep
- best_valid_out  output  1  last sweep captured at least one range

## Operation
- States: IDLE, BURST, LISTEN, PUBLISH. A single dwell counter runs 0..PERIOD_CYCLES-1.
- IDLE → BURST when enable_in=1.
  - Counter cleared, beam_angle_out = sweep start angle, burst_start_out = 1 on the first BURST cycle.
- BURST → LISTEN when counter = BURST_CYCLES-1.
- LISTEN end (counter = PERIOD_CYCLES-1):
  - Last angle of the sweep → PUBLISH.
  - Otherwise → BURST, with angle += step and counter cleared.
- PUBLISH (exactly one cycle):
  - Pulses sweep_done_out and updates the best_* outputs.
  - Goes to BURST (next sweep) if enable_in=1, else to IDLE.
  - enable_in deasserted mid-sweep takes effect only here.
- Range capture:
  - Only the first result_valid_in of a LISTEN dwell is accepted. Later strobes in the same dwell are ignored.
  - Strobes in IDLE, BURST or PUBLISH are ignored.
- Nearest-target tracking:
  - A running minimum per sweep, using an unsigned compare.
  - A strictly smaller range replaces the minimum; on a tie the earlier dwell is kept.
  - Range 0 is a legal capture.
  - The running minimum is cleared at sweep start.
- At PUBLISH:
  - If any capture occurred: best_angle_out, best_range_out ← running minimum and its angle; best_valid_out ← 1.
  - If none occurred: best_valid_out ← 0, and best_angle_out/best_range_out hold their previous values.
- Reset values: state IDLE, all strobes 0, beam_angle_out = ANGLE_MIN, best_angle_out = 0, best_range_out = 0, best_valid_out = 0.
- Reset mid-operation: every register returns to its reset value on the next edge. No PUBLISH occurs.

## Timing
- Registered outputs; no combinational path from input to output.
- Enable sampled in IDLE at cycle t → burst_start_out and burst_active_out high at t+1.
- Dwell k (k = 0..N-1, N = (ANGLE_MAX-ANGLE_MIN)/ANGLE_STEP+1) starts at t+1+k·PERIOD_CYCLES.
- burst_active_out and listen_active_out are mutually exclusive and both low in IDLE and PUBLISH.
- PUBLISH at t+1+N·PERIOD_CYCLES. Under continuous enable, the next sweep's burst_start_out follows one cycle later; sweep period = N·PERIOD_CYCLES+1.
- A result strobe on the final LISTEN cycle is captured and included in that sweep's PUBLISH.
- beam_angle_out changes on the same edge that asserts burst_start_out and is stable for the whole dwell.

## Configuration
- SWEEP_PING_PONG_EN defined:
  - Sweep direction reverses after each PUBLISH; the next sweep starts at the endpoint just finished, so the endpoint dwell is repeated.
  - The sequence is -30..30, then 30..-30, and so on.
  - Reset sets the direction to ascending.
- Undefined: every sweep starts at ANGLE_MIN ascending.

## Test plan
Parameters for all scenarios: PERIOD_CYCLES=20, BURST_CYCLES=4, defaults otherwise.

- Reset, then enable_in=1 at cycle 0 → burst_start_out pulses at cycles 1, 21, …, 121 with angles -30, -20, …, 30; burst_active_out high for 4 cycles of each dwell; sweep_done_out at cycle 141; next burst at cycle 142.
- Ranges 500@-10, 120@20, 120@30 → at PUBLISH best_angle=20, best_range=120, best_valid=1.
- No strobes in a sweep → sweep_done_out pulses, best_valid_out=0, previous best values held.
- In one dwell, a strobe during BURST (range 10), then 300, then 50 in LISTEN → 300 captured.
- rst_in for one cycle mid-LISTEN at angle 0 → outputs reach reset values the next cycle, no sweep_done_out; with enable held, the sweep restarts at -30.
- SWEEP_PING_PONG_EN defined, two sweeps → second-sweep angles 30, 20, …, -30; best_angle is correct for that order.
